// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                      |
// | Description : Shared PS/2 definitions. Includes the transmitter state      |
// |               encoding, common keyboard command bytes and the odd-parity   |
// |               helper used to build a frame.                                |
// | Revision    : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // The PS/2 parity bit makes the total count of ones in data plus parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_sync_edge                                                |
// | Description : 2-FF synchronizer for the PS/2 clock and data pins, plus a   |
// |               one-cycle strobe on a synchronized clock falling edge.       |
// |               The receiver uses the same block on the same pins.           |
// | Ports       : clk_i, rst_i        - system clock, async active-high reset  |
// |               ps2_clk_i/ps2_data_i - raw pin levels                        |
// |               clk_sync_o/data_sync_o - synchronized levels                 |
// |               fall_o               - synced clock went 1 -> 0              |
// | Revision    : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic fall_o
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_data_meta;
    logic r_data_sync;

    // Reset to the idle bus level (high) so leaving reset never fakes an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_i;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_i;
            r_data_sync <= r_data_meta;
        end
    end

    assign clk_sync_o  = r_clk_sync;
    assign data_sync_o = r_data_sync;
    assign fall_o      = r_clk_prev & ~r_clk_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_tx                                                       |
// | Description : Host-to-device PS/2 transmitter. Runs request-to-send,       |
// |               shifts 8 data bits, odd parity and stop on device clocks,    |
// |               then checks the device line-ack. A watchdog aborts a stalled |
// |               transfer.                                                    |
// | Ports       : clk_i, rst_i            - clock, async active-high reset     |
// |               ps2_clk_i, ps2_data_i   - pin levels                         |
// |               data_i, start_i         - byte and send request              |
// |               busy_o, done_o, err_o   - status / one-cycle result pulses   |
// |               ps2_clk_oe_o, ps2_data_oe_o - 1 pulls the pin low            |
// | Revision    : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int c_cnt_w = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_inhibit_last = c_cnt_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic w_clk_sync;
    logic w_data_sync;
    logic w_fall;
    logic w_timeout;

    ps2_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_shift;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_done;
    logic               r_err;

    ps2_sync_edge u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .clk_sync_o  (w_clk_sync),
        .data_sync_o (w_data_sync),
        .fall_o      (w_fall)
    );

    // r_cnt doubles as inhibit timer and watchdog; only one is live at a time.
    assign w_timeout = (r_cnt == c_timeout_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (start_i) begin
                        r_shift  <= {1'b1, odd_parity(data_i), data_i};
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (r_cnt == c_inhibit_last) begin
                        // Start bit goes out while the clock is still held.
                        r_data_oe <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= RTS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RTS: begin
                    r_clk_oe  <= 1'b0;
                    r_bit_cnt <= '0;
                    r_cnt     <= '0;
                    r_state   <= SHIFT;
                end

                SHIFT: begin
                    if (w_fall) begin
                        // Update right after the falling edge; the device
                        // samples on the following rising edge.
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= {1'b1, r_shift[9:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_cnt     <= '0;
                        if (r_bit_cnt == 4'd9) begin
                            r_state <= WAIT_ACK;
                        end
                    end else if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                WAIT_ACK: begin
                    if (w_fall) begin
                        r_cnt <= '0;
                        if (!w_data_sync) begin
                            r_state <= WAIT_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (w_clk_sync && w_data_sync) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_fall) begin
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = (r_state != IDLE);
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign ps2_clk_oe_o  = r_clk_oe;
    assign ps2_data_oe_o = r_data_oe;

endmodule
`default_nettype wire
